// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B (mod 2^WIDTH) plus final borrow, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output OVF.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
`ifdef SERIAL_SUB_OVF_EN
    output logic             OVF,
`endif
    output logic [1:0]       state_dbg
);

    localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    logic             d_bit;
    logic             br_next;
    logic [WIDTH:0]   res_wide;
    logic [WIDTH-1:0] res_next;

    // Full-subtractor cell on the current LSBs; the new bit enters the result at the MSB.
    always_comb begin
        d_bit    = a_sr[0] ^ b_sr[0] ^ br;
        br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        res_wide = {d_bit, res};
        res_next = res_wide[WIDTH:1];
    end

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            D     <= '0;
            Bout  <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            OVF   <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    busy <= 1'b0;
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        res   <= '0;
                        br    <= 1'b0;
                        cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= A[WIDTH-1];
                        b_msb <= B[WIDTH-1];
`endif
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    res  <= res_next;
                    br   <= br_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // Final bit: publish the result on the same edge it completes.
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        D     <= res_next;
                        Bout  <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        OVF   <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
`endif
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); covers OVF when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] D;
    logic         Bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         OVF;
`endif
    logic [1:0]   state_dbg;

    int checks;
    int errors;
    logic [W-1:0] prev_d;
    logic         prev_b;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .D         (D),
        .Bout      (Bout),
`ifdef SERIAL_SUB_OVF_EN
        .OVF       (OVF),
`endif
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an operation from IDLE or from a DONE cycle and returns in its done cycle.
    // inject > 0 re-asserts start with other operands in that busy cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_d, input logic exp_b, input int inject);
        start = 1'b1;
        A = a;
        B = b;
        tick();
        start = 1'b0;
        A = W'($urandom_range(0, 255));
        B = W'($urandom_range(0, 255));
        for (int i = 1; i <= W; i++) begin
            check("busy_shift", {31'b0, busy}, 32'd1);
            check("done_shift", {31'b0, done}, 32'd0);
            check("d_hold_shift", {24'b0, D}, {24'b0, prev_d});
            if (i == 1) check("state_shift", {30'b0, state_dbg}, 32'd1);
            if (i == inject) begin
                start = 1'b1;
                A = 8'hFF;
                B = 8'h00;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check("done_pulse", {31'b0, done}, 32'd1);
        check("busy_done", {31'b0, busy}, 32'd0);
        check("d_result", {24'b0, D}, {24'b0, exp_d});
        check("bout_result", {31'b0, Bout}, {31'b0, exp_b});
        prev_d = exp_d;
        prev_b = exp_b;
    endtask

    // Idle cycles after a done: no further done, results held.
    task automatic idle_hold(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("done_idle", {31'b0, done}, 32'd0);
            check("busy_idle", {31'b0, busy}, 32'd0);
            check("d_hold_idle", {24'b0, D}, {24'b0, prev_d});
            check("bout_hold_idle", {31'b0, Bout}, {31'b0, prev_b});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        prev_d = '0;
        prev_b = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_d", {24'b0, D}, 32'd0);
        check("rst_bout", {31'b0, Bout}, 32'd0);
        check("rst_state", {30'b0, state_dbg}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", {31'b0, OVF}, 32'd0);
`endif
        tick();

        // 100 - 37 = 63; D must still read 63 three cycles later (cycle 12)
        run_op(8'd100, 8'd37, 8'd63, 1'b0, 0);
        idle_hold(3);

        run_op(8'h00, 8'h01, 8'hFF, 1'b1, 0);
        idle_hold(1);
        run_op(8'hAA, 8'hAA, 8'h00, 1'b0, 0);
        idle_hold(1);

        // start during SHIFT (cycle 4) with 0xFF - 0x00 is ignored
        run_op(8'd100, 8'd37, 8'd63, 1'b0, 4);
        idle_hold(3);

        // reset in cycle 5 of an operation
        start = 1'b1;
        A = 8'h37;
        B = 8'h12;
        tick();
        start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_d", {24'b0, D}, 32'd0);
        check("midrst_bout", {31'b0, Bout}, 32'd0);
        check("midrst_state", {30'b0, state_dbg}, 32'd0);
        prev_d = '0;
        prev_b = 1'b0;
        idle_hold(12);

        // fresh start after reset, then back-to-back from its done cycle
        run_op(8'h37, 8'h12, 8'h25, 1'b0, 0);
        run_op(8'd5, 8'd7, 8'hFE, 1'b1, 0);
        idle_hold(2);

`ifdef SERIAL_SUB_OVF_EN
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 0);
        check("ovf_set", {31'b0, OVF}, 32'd1);
        idle_hold(1);
        check("ovf_hold", {31'b0, OVF}, 32'd1);
        run_op(8'h10, 8'h01, 8'h0F, 1'b0, 0);
        check("ovf_clear", {31'b0, OVF}, 32'd0);
        idle_hold(1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
